// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipelined_carry_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry add/subtract: one SEG-bit ripple segment per stage, carry registered
// between stages, whole pipe advancing together on a single enable (no bubble collapse).
module pipelined_carry_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_carry_adder_if.slave bus
);
  localparam int NSTG = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipelined_carry_adder: WIDTH must be a positive multiple of SEG");
  end

  logic             en;
  logic             out_valid_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;

  assign en            = !out_valid_reg || bus.out_ready;
  assign bus.in_ready  = en && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

  // Stage gi sees only the operand bits not yet consumed (RW wide); its segment is the low SEG bits.
  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
    localparam int RW = WIDTH - gi * SEG;

    logic [RW-1:0]  a_in;
    logic [RW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [SEG:0]   c;
    logic [SEG-1:0] s;

    if (gi == 0) begin : g_head
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.sub | bus.cin;
      assign v_in = bus.in_valid & bus.in_ready;
    end else begin : g_body
      logic [RW-1:0]       a_reg;
      logic [RW-1:0]       b_reg;
      logic                c_reg;
      logic                v_reg;
      logic [gi*SEG-1:0]   lo_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
        end else if (en) begin
          v_reg <= g_stg[gi-1].v_in;
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          c_reg <= g_stg[gi-1].c[SEG];
          a_reg <= g_stg[gi-1].a_in[RW+SEG-1:SEG];
          b_reg <= g_stg[gi-1].b_in[RW+SEG-1:SEG];
        end
      end

      // Completed lower sum segments ride along so every segment of one op exits together.
      if (gi == 1) begin : g_lo_first
        always_ff @(posedge clk) begin
          if (en) begin
            lo_reg <= g_stg[0].s;
          end
        end
      end else begin : g_lo_chain
        always_ff @(posedge clk) begin
          if (en) begin
            lo_reg <= {g_stg[gi-1].s, g_stg[gi-1].g_body.lo_reg};
          end
        end
      end

      assign a_in = a_reg;
      assign b_in = b_reg;
      assign c_in = c_reg;
      assign v_in = v_reg;
    end

    always_comb begin
      s    = '0;
      c    = '0;
      c[0] = c_in;
      for (int j = 0; j < SEG; j++) begin
        s[j]   = a_in[j] ^ b_in[j] ^ c[j];
        c[j+1] = (a_in[j] & b_in[j]) | (c[j] & (a_in[j] ^ b_in[j]));
      end
    end
  end

  if (NSTG == 1) begin : g_sum_single
    assign sum_next = g_stg[0].s;
  end else begin : g_sum_multi
    assign sum_next = {g_stg[NSTG-1].s, g_stg[NSTG-1].g_body.lo_reg};
  end

  // Result registers only load when a valid slot arrives, so bubbles never disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (en) begin
      out_valid_reg <= g_stg[NSTG-1].v_in;
      if (g_stg[NSTG-1].v_in) begin
        sum_reg  <= sum_next;
        cout_reg <= g_stg[NSTG-1].c[SEG];
        ovf_reg  <= g_stg[NSTG-1].c[SEG] ^ g_stg[NSTG-1].c[SEG-1];
      end
    end
  end
endmodule
